// File: rtl/alu_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin ALU arbiter slice.
// Operand width, opcodes and requester IDs live here so every file agrees.
package alu_rr_arbiter_pkg;

    localparam int   ALU_W  = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic REQ0   = 1'b0;
    localparam logic REQ1   = 1'b1;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic             op;
    } alu_req_t;

endpackage

// File: rtl/ALU4bit.sv
// Four-bit two's-complement add/sub unit with signed overflow flag.
// Overflow is the carry into the MSB XOR the carry out of the MSB.
module ALU4bit
    import alu_rr_arbiter_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             operator,
    output logic [ALU_W-1:0] s,
    output logic             overflow
);

    logic [ALU_W-1:0] w_bx;
    logic [ALU_W:0]   w_sum;
    logic [ALU_W-1:0] w_lowSum;

    // Subtraction is a + ~b + 1, so the operator doubles as carry-in.
    assign w_bx     = b ^ {ALU_W{operator}};
    assign w_sum    = {1'b0, a} + {1'b0, w_bx} + {{ALU_W{1'b0}}, operator};
    assign w_lowSum = {1'b0, a[ALU_W-2:0]} + {1'b0, w_bx[ALU_W-2:0]}
                    + {{(ALU_W-1){1'b0}}, operator};

    assign s        = w_sum[ALU_W-1:0];
    assign overflow = w_sum[ALU_W] ^ w_lowSum[ALU_W-1];

endmodule

// File: rtl/alu_rr_arbiter_grant.sv
// Two-way grant selector: round-robin on last_grant, or fixed priority to req0.
// Produces a one-hot (or zero) grant vector, only while the slot is free.
module rr_grant2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       slot_free,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (slot_free) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
                    if (FIXED_PRIO || last_grant) grant = 2'b01;
                    else                          grant = 2'b10;
                end
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two requesters share one ALU4bit; results pass through a single registered
// response slot with valid/ready handshake and a saturating overflow counter.
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [ALU_W-1:0] rsp_s,
    output logic             rsp_overflow,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic             r_rspValid;
    logic             r_rspId;
    logic [ALU_W-1:0] r_rspS;
    logic             r_rspOverflow;
    logic [CNT_W-1:0] r_ovfCnt;
    logic             r_lastGrant;

    logic             w_slotFree;
    logic [1:0]       w_grant;
    alu_req_t         w_sel;
    logic [ALU_W-1:0] w_aluS;
    logic             w_aluOverflow;
    logic             w_rspHandshake;

    // Grants are suppressed during reset so no requester sees a handshake then.
    assign w_slotFree     = (!r_rspValid || rsp_ready) && !rst;
    assign w_rspHandshake = r_rspValid && rsp_ready;

    rr_grant2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_grant (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (r_lastGrant),
        .slot_free  (w_slotFree),
        .grant      (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    assign w_sel = w_grant[1] ? '{a: req1_a, b: req1_b, op: req1_op}
                              : '{a: req0_a, b: req0_b, op: req0_op};

    ALU4bit u_alu (
        .a        (w_sel.a),
        .b        (w_sel.b),
        .operator (w_sel.op),
        .s        (w_aluS),
        .overflow (w_aluOverflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rspValid    <= 1'b0;
            r_rspId       <= REQ0;
            r_rspS        <= '0;
            r_rspOverflow <= 1'b0;
            r_ovfCnt      <= '0;
            r_lastGrant   <= REQ1;
        end else begin
            if (w_rspHandshake && r_rspOverflow && (r_ovfCnt != {CNT_W{1'b1}}))
                r_ovfCnt <= r_ovfCnt + CNT_W'(1);
            // A new grant overwrites an accepted response in the same edge.
            if (|w_grant) begin
                r_rspValid    <= 1'b1;
                r_rspId       <= w_grant[1] ? REQ1 : REQ0;
                r_rspS        <= w_aluS;
                r_rspOverflow <= w_aluOverflow;
                r_lastGrant   <= w_grant[1] ? REQ1 : REQ0;
            end else if (rsp_ready) begin
                r_rspValid <= 1'b0;
            end
        end
    end

    assign rsp_valid    = r_rspValid;
    assign rsp_id       = r_rspId;
    assign rsp_s        = r_rspS;
    assign rsp_overflow = r_rspOverflow;
    assign ovf_cnt      = r_ovfCnt;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench: round-robin instance with default parameters plus a
// fixed-priority, 2-bit-counter instance for saturation and priority checks.
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;

    logic       req0_valid, req0_ready, req0_op;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_op;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_overflow;
    logic [3:0] rsp_s;
    logic [7:0] ovf_cnt;

    logic       p0Valid, p0Ready, p0Op;
    logic [3:0] p0A, p0B;
    logic       p1Valid, p1Ready, p1Op;
    logic [3:0] p1A, p1B;
    logic       pRspValid, pRspReady, pRspId, pRspOverflow;
    logic [3:0] pRspS;
    logic [1:0] pOvfCnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter dut (
        .clk (clk), .rst (rst),
        .req0_valid (req0_valid), .req0_ready (req0_ready),
        .req0_a (req0_a), .req0_b (req0_b), .req0_op (req0_op),
        .req1_valid (req1_valid), .req1_ready (req1_ready),
        .req1_a (req1_a), .req1_b (req1_b), .req1_op (req1_op),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id (rsp_id),
        .rsp_s (rsp_s), .rsp_overflow (rsp_overflow), .ovf_cnt (ovf_cnt)
    );

    alu_rr_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(2)) dutPrio (
        .clk (clk), .rst (rst),
        .req0_valid (p0Valid), .req0_ready (p0Ready),
        .req0_a (p0A), .req0_b (p0B), .req0_op (p0Op),
        .req1_valid (p1Valid), .req1_ready (p1Ready),
        .req1_a (p1A), .req1_b (p1B), .req1_op (p1Op),
        .rsp_valid (pRspValid), .rsp_ready (pRspReady), .rsp_id (pRspId),
        .rsp_s (pRspS), .rsp_overflow (pRspOverflow), .ovf_cnt (pOvfCnt)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                                 input logic op0, input logic v1, input logic [3:0] a1,
                                 input logic [3:0] b1, input logic op1, input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = rr;
    endtask

    task automatic checkRsp(input string tag, input logic v, input logic id,
                            input logic [3:0] s, input logic ovf, input logic [7:0] cnt);
        checkOutput({tag, ".valid"}, {7'd0, rsp_valid}, {7'd0, v});
        checkOutput({tag, ".id"}, {7'd0, rsp_id}, {7'd0, id});
        checkOutput({tag, ".s"}, {4'd0, rsp_s}, {4'd0, s});
        checkOutput({tag, ".ovf"}, {7'd0, rsp_overflow}, {7'd0, ovf});
        checkOutput({tag, ".cnt"}, ovf_cnt, cnt);
    endtask

    task automatic checkReady(input string tag, input logic r0, input logic r1);
        checkOutput({tag, ".rdy0"}, {7'd0, req0_ready}, {7'd0, r0});
        checkOutput({tag, ".rdy1"}, {7'd0, req1_ready}, {7'd0, r1});
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0);
        p0Valid = 0; p0A = 0; p0B = 0; p0Op = 0;
        p1Valid = 0; p1A = 0; p1B = 0; p1Op = 0;
        pRspReady = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkRsp("reset", 0, 0, 4'h0, 0, 8'd0);

        // req0 alone: 3 + 4 = 7
        applyStimulus(1, 4'b0011, 4'b0100, 0, 0, 4'h0, 4'h0, 0, 1);
        #1 checkReady("solo0", 1, 0);
        @(negedge clk);
        checkRsp("solo0.rsp", 1, 0, 4'b0111, 0, 8'd0);
        applyStimulus(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1);
        @(negedge clk);
        checkOutput("solo0.drain", {7'd0, rsp_valid}, 8'd0);

        // req1 alone: 7 + 1 overflows to 1000
        applyStimulus(0, 4'h0, 4'h0, 0, 1, 4'b0111, 4'b0001, 0, 1);
        #1 checkReady("solo1", 0, 1);
        @(negedge clk);
        checkRsp("solo1.rsp", 1, 1, 4'b1000, 1, 8'd0);
        applyStimulus(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1);
        @(negedge clk);
        checkRsp("solo1.drain", 0, 1, 4'b1000, 1, 8'd1);

        // Contention: req0 8-1 (ovf), req1 5-3; last grant was req1
        applyStimulus(1, 4'b1000, 4'b0001, 1, 1, 4'b0101, 4'b0011, 1, 1);
        #1 checkReady("rr.g0", 1, 0);
        @(negedge clk);
        checkRsp("rr.r0", 1, 0, 4'b0111, 1, 8'd1);
        checkReady("rr.g1", 0, 1);
        @(negedge clk);
        checkRsp("rr.r1", 1, 1, 4'b0010, 0, 8'd2);
        checkReady("rr.g2", 1, 0);
        @(negedge clk);
        checkRsp("rr.r2", 1, 0, 4'b0111, 1, 8'd2);
        checkReady("rr.g3", 0, 1);
        @(negedge clk);
        checkRsp("rr.r3", 1, 1, 4'b0010, 0, 8'd3);

        // Backpressure for three cycles
        rsp_ready = 1'b0;
        #1 checkReady("hold.enter", 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkRsp("hold", 1, 1, 4'b0010, 0, 8'd3);
            checkReady("hold", 0, 0);
        end
        rsp_ready = 1'b1;
        #1 checkReady("hold.release", 1, 0);
        @(negedge clk);
        checkRsp("hold.rsp", 1, 0, 4'b0111, 1, 8'd3);

        // Reset with a response pending; requesters stay valid
        rst = 1'b1;
        #1 checkReady("rst.cycle", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        checkRsp("rst.rsp", 0, 0, 4'h0, 0, 8'd0);
        #1 checkReady("rst.first", 1, 0);
        @(negedge clk);
        checkRsp("rst.after", 1, 0, 4'b0111, 1, 8'd0);
        applyStimulus(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1);

        // Fixed priority + 2-bit saturating counter: req0 always 7+1 (ovf)
        p0Valid = 1; p0A = 4'b0111; p0B = 4'b0001; p0Op = 0;
        p1Valid = 1; p1A = 4'b0000; p1B = 4'b0000; p1Op = 0;
        pRspReady = 1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            checkOutput("prio.rdy0", {7'd0, p0Ready}, 8'd1);
            checkOutput("prio.rdy1", {7'd0, p1Ready}, 8'd0);
            checkOutput("prio.id", {7'd0, pRspId}, 8'd0);
            checkOutput("prio.cnt", {6'd0, pOvfCnt}, (n - 1 > 3) ? 8'd3 : 8'(n - 1));
        end
        p0Valid = 0; p1Valid = 0;
        @(negedge clk);
        checkOutput("sat.cnt", {6'd0, pOvfCnt}, 8'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
